// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] X0 = {REG_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } ecall_state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } stage_rec_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage fields in, pipeline sequencing controls out; master is the core side,
// slave is the hazard controller.
interface hazard_ctrl_if #(parameter int REG_W = hazard_pkg::REG_W);

  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_ecall;
  logic             ex_branch_taken;
  logic             ecall_done;
  logic             fwd_ex_1;
  logic             fwd_ex_2;
  logic             fwd_mem_1;
  logic             fwd_mem_2;
  logic             stall_if;
  logic             flush_if;
  logic             clear_id;
  logic             ecall_req;
  logic             busy;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, id_ecall, ex_branch_taken, ecall_done,
    input  fwd_ex_1, fwd_ex_2, fwd_mem_1, fwd_mem_2, stall_if, flush_if,
           clear_id, ecall_req, busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, id_ecall, ex_branch_taken, ecall_done,
    output fwd_ex_1, fwd_ex_2, fwd_mem_1, fwd_mem_2, stall_if, flush_if,
           clear_id, ecall_req, busy
  );

endinterface

// File: rtl/hazard_match.sv
// Compares one ID source register against one shadow stage record; x0 never matches.
module hazard_match
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  stage_rec_t       rec,
  output logic             hit
);

  logic unused_s;

  assign hit = use_src && rec.valid && rec.reg_write &&
               (rec.rd != X0) && (rec.rd == src);

  // The load flag belongs to the record but is interpreted by the caller.
  assign unused_s = rec.mem_read;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow EX/MEM/WB records, forwarding, load-use stall,
// branch flush and ecall drain. Define HAZARD_FWD_EN to enable operand forwarding.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W = hazard_pkg::REG_W
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  stage_rec_t   ex_r;
  stage_rec_t   mem_r;
  stage_rec_t   wb_r;
  stage_rec_t   id_rec_s;
  ecall_state_t state_r;
  ecall_state_t state_nxt_s;

  logic ex_hit1_s;
  logic ex_hit2_s;
  logic mem_hit1_s;
  logic mem_hit2_s;
  logic fwd_ex1_s;
  logic fwd_ex2_s;
  logic fwd_mem1_s;
  logic fwd_mem2_s;
  logic data_stall_s;
  logic pipe_empty_s;
  logic stall_s;
  logic flush_s;
  logic clear_s;
  logic req_s;
  logic unused_s;

  hazard_match u_ex1  (.src(bus.id_rs1), .use_src(bus.id_use_rs1), .rec(ex_r),  .hit(ex_hit1_s));
  hazard_match u_ex2  (.src(bus.id_rs2), .use_src(bus.id_use_rs2), .rec(ex_r),  .hit(ex_hit2_s));
  hazard_match u_mem1 (.src(bus.id_rs1), .use_src(bus.id_use_rs1), .rec(mem_r), .hit(mem_hit1_s));
  hazard_match u_mem2 (.src(bus.id_rs2), .use_src(bus.id_use_rs2), .rec(mem_r), .hit(mem_hit2_s));

`ifdef HAZARD_FWD_EN
  // A load in EX has no result yet, so it cannot feed the EX bypass.
  assign fwd_ex1_s    = ex_hit1_s && !ex_r.mem_read;
  assign fwd_ex2_s    = ex_hit2_s && !ex_r.mem_read;
  assign fwd_mem1_s   = mem_hit1_s && !ex_hit1_s;
  assign fwd_mem2_s   = mem_hit2_s && !ex_hit2_s;
  assign data_stall_s = (ex_hit1_s || ex_hit2_s) && ex_r.mem_read;
`else
  assign fwd_ex1_s    = 1'b0;
  assign fwd_ex2_s    = 1'b0;
  assign fwd_mem1_s   = 1'b0;
  assign fwd_mem2_s   = 1'b0;
  assign data_stall_s = ex_hit1_s || ex_hit2_s || mem_hit1_s || mem_hit2_s;
`endif

  assign pipe_empty_s = !ex_r.valid && !mem_r.valid && !wb_r.valid;

  // WB only matters for drain detection; its other fields simply retire.
  assign unused_s = ^{wb_r.rd, wb_r.reg_write, wb_r.mem_read};

  // Record entering EX: the ID instruction, or a bubble when ID/EX is cleared.
  always_comb begin
    id_rec_s = '{valid: 1'b0, rd: {REG_W{1'b0}}, reg_write: 1'b0, mem_read: 1'b0};
    if (bus.id_valid && !clear_s) begin
      id_rec_s = '{valid: 1'b1, rd: bus.id_rd, reg_write: bus.id_reg_write,
                   mem_read: bus.id_mem_read};
    end else begin
      id_rec_s = '{valid: 1'b0, rd: {REG_W{1'b0}}, reg_write: 1'b0, mem_read: 1'b0};
    end
  end

  // Ecall sequencing and stall/flush/bubble selection.
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    flush_s     = 1'b0;
    clear_s     = 1'b0;
    req_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.ex_branch_taken) begin
          flush_s = 1'b1;
          clear_s = 1'b1;
        end else if (data_stall_s) begin
          stall_s = 1'b1;
          clear_s = 1'b1;
        end else if (bus.id_valid && bus.id_ecall) begin
          // Hold the ecall in ID from its first cycle so it enters EX only at release.
          stall_s     = 1'b1;
          clear_s     = 1'b1;
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (bus.ex_branch_taken) begin
          flush_s     = 1'b1;
          clear_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (pipe_empty_s) begin
          stall_s     = 1'b1;
          clear_s     = 1'b1;
          state_nxt_s = ST_WAIT;
        end else begin
          stall_s     = 1'b1;
          clear_s     = 1'b1;
        end
      end
      ST_WAIT: begin
        stall_s = 1'b1;
        clear_s = 1'b1;
        req_s   = 1'b1;
        if (bus.ecall_done) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RELEASE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Shadow pipeline advance and ecall state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r    <= '{valid: 1'b0, rd: {REG_W{1'b0}}, reg_write: 1'b0, mem_read: 1'b0};
      mem_r   <= '{valid: 1'b0, rd: {REG_W{1'b0}}, reg_write: 1'b0, mem_read: 1'b0};
      wb_r    <= '{valid: 1'b0, rd: {REG_W{1'b0}}, reg_write: 1'b0, mem_read: 1'b0};
      state_r <= ST_IDLE;
    end else begin
      ex_r    <= id_rec_s;
      mem_r   <= ex_r;
      wb_r    <= mem_r;
      state_r <= state_nxt_s;
    end
  end

  assign bus.fwd_ex_1  = fwd_ex1_s  && !rst;
  assign bus.fwd_ex_2  = fwd_ex2_s  && !rst;
  assign bus.fwd_mem_1 = fwd_mem1_s && !rst;
  assign bus.fwd_mem_2 = fwd_mem2_s && !rst;
  assign bus.stall_if  = stall_s    && !rst;
  assign bus.flush_if  = flush_s    && !rst;
  assign bus.clear_id  = clear_s    && !rst;
  assign bus.ecall_req = req_s      && !rst;
  assign bus.busy      = (state_r != ST_IDLE) && !rst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl; expectations adapt to HAZARD_FWD_EN.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_W(REG_W)) hif ();

  hazard_ctrl #(.REG_W(REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  // Output vector: {fwd_ex_1, fwd_ex_2, fwd_mem_1, fwd_mem_2, stall_if, flush_if, clear_id, ecall_req, busy}
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] FE1  = 9'b100000000;
  localparam logic [8:0] FE2  = 9'b010000000;
  localparam logic [8:0] FM1  = 9'b001000000;
  localparam logic [8:0] FM2  = 9'b000100000;
  localparam logic [8:0] ST   = 9'b000010000;
  localparam logic [8:0] FL   = 9'b000001000;
  localparam logic [8:0] CL   = 9'b000000100;
  localparam logic [8:0] RQ   = 9'b000000010;
  localparam logic [8:0] BY   = 9'b000000001;
  localparam logic [8:0] STL  = ST | CL;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic [8:0] exp_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  function automatic logic [8:0] outs();
    return {hif.fwd_ex_1, hif.fwd_ex_2, hif.fwd_mem_1, hif.fwd_mem_2,
            hif.stall_if, hif.flush_if, hif.clear_id, hif.ecall_req, hif.busy};
  endfunction

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic ec);
    hif.id_valid     = v;
    hif.id_rs1       = rs1;
    hif.id_use_rs1   = u1;
    hif.id_rs2       = rs2;
    hif.id_use_rs2   = u2;
    hif.id_rd        = rd;
    hif.id_reg_write = rw;
    hif.id_mem_read  = mr;
    hif.id_ecall     = ec;
  endtask

  task automatic set_ctl(input logic br, input logic done);
    hif.ex_branch_taken = br;
    hif.ecall_done      = done;
  endtask

  task automatic idle_in();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    set_ctl(1'b0, 1'b0);
  endtask

  // Inputs are already applied; score at the falling edge, then move past the next rising edge.
  task automatic step(input string tag, input logic [8:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    check_eq(tag_q.pop_front(), outs(), exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic drain3(input string tag);
    idle_in();
    for (int i = 0; i < 3; i++) step(tag, NONE);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset masks every output even with hazards and branch asserted.
    rst = 1'b1;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
    set_ctl(1'b1, 1'b1);
    step("reset0", NONE);
    step("reset1", NONE);
    rst = 1'b0;
    idle_in();
    step("post_reset", NONE);

    // ALU producer x5 then consumer of rs1=x5.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    step("addi_x5", NONE);
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    step("fwd_ex_rs1", FWD ? FE1 : STL);
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("fwd_mem_rs1", FWD ? FM1 : STL);
    step("wb_no_fwd", NONE);
    drain3("drain_a");

    // Load-use on rs2.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    step("lw_x6", NONE);
    set_id(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    step("load_use", STL);
    step("load_fwd_mem", FWD ? FM2 : STL);
    step("load_done", NONE);
    drain3("drain_b");

    // rs1 from EX and rs2 from MEM in the same cycle.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    step("addi_x3", NONE);
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    step("addi_x4", NONE);
    set_id(1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    step("dual_src", FWD ? (FE1 | FM2) : STL);
    drain3("drain_c");

    // EX wins over MEM for the same register.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    step("addi_x10_a", NONE);
    step("addi_x10_b", NONE);
    set_id(1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    step("ex_priority", FWD ? (FE1 | FE2) : STL);
    drain3("drain_d");

    // x0 never matches, even behind a load.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    step("lw_x0", NONE);
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    step("x0_ex", NONE);
    step("x0_mem", NONE);
    drain3("drain_e");

    // Branch overrides load-use stall.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    step("lw_x6_b", NONE);
    set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    set_ctl(1'b1, 1'b0);
    step("branch_vs_load", FL | CL);
    drain3("drain_f");

    // Branch kills ecall entry.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    set_ctl(1'b1, 1'b0);
    step("branch_vs_ecall", FL | CL);
    idle_in();
    step("no_ecall_entry", NONE);

    // Ecall behind three older writers.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
    step("older1", NONE);
    hif.id_rd = 5'd12;
    step("older2", NONE);
    hif.id_rd = 5'd13;
    step("older3", NONE);
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("ecall_entry", STL);
    step("drain1", STL | BY);
    step("drain2", STL | BY);
    step("drain3", STL | BY);
    step("wait", STL | RQ | BY);
    set_ctl(1'b0, 1'b1);
    step("wait_done", STL | RQ | BY);
    step("release", BY);
    idle_in();
    set_ctl(1'b0, 1'b1);
    step("done_ignored", NONE);

    // Reset during WAIT.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    set_ctl(1'b0, 1'b0);
    step("ecall2_entry", STL);
    step("ecall2_drain1", STL | BY);
    step("ecall2_drain2", STL | BY);
    step("ecall2_wait", STL | RQ | BY);
    rst = 1'b1;
    set_ctl(1'b1, 1'b1);
    step("rst_in_wait", NONE);
    rst = 1'b0;
    idle_in();
    step("idle_after_rst", NONE);

    // Branch during DRAIN aborts the ecall.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("ecall3_entry", STL);
    set_ctl(1'b1, 1'b0);
    step("drain_branch", FL | CL | BY);
    idle_in();
    step("drain_aborted", NONE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
